// File: rtl/valtrain_pattern_gen.sv
// rtl/valtrain_pattern_gen.sv - valid-lane training pattern generator for the mainband TX path
// Bounded bursts of the replicated valid pattern, or open-ended framing, handshaked with the serializer.
module valtrain_pattern_gen #(
  parameter int          DATA_W   = 32,
  parameter int          CNT_W    = 7,
  parameter logic [7:0]  BASE_PAT = 8'hF0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_pattern_en,
  input  logic              i_frame_en,
  input  logic [CNT_W-1:0]  i_burst_len,
  input  logic              i_clear,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_tvld,
  output logic              o_tvld_valid,
  output logic              o_enable_detector,
  output logic              o_done,
  output logic              o_busy,
  output logic [CNT_W-1:0]  o_beat_cnt
);

  if ((DATA_W % 8) != 0 || DATA_W < 8) begin : g_bad_width
    $error("DATA_W must be a non-zero multiple of 8");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PATTERN = 2'd1,
    FRAMING = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] len, len_nxt;
  logic             xfer;
  logic             last_beat;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      len   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      len   <= len_nxt;
    end
  end

  assign xfer = o_tvld_valid & i_ready;
  // A latched length of 0 makes len-1 wrap to all ones, giving the full 2^CNT_W burst.
  assign last_beat = (cnt == (len - CNT_ONE));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    len_nxt   = len;
    case (state)
      IDLE: begin
        if (i_pattern_en) begin
          state_nxt = PATTERN;
          len_nxt   = i_burst_len;
          cnt_nxt   = '0;
        end else if (i_frame_en) begin
          state_nxt = FRAMING;
          cnt_nxt   = '0;
        end
      end
      PATTERN: begin
        if (xfer) begin
          cnt_nxt = cnt + CNT_ONE;
          if (last_beat) state_nxt = DONE;
        end
      end
      DONE: begin
        if (!i_pattern_en) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      FRAMING: begin
        cnt_nxt = '0;
        if (!i_frame_en) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    if (i_clear) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end
  end

  assign o_tvld_valid      = (state == PATTERN) || (state == FRAMING);
  assign o_tvld            = o_tvld_valid ? {(DATA_W/8){BASE_PAT}} : '0;
  assign o_enable_detector = (state == PATTERN);
  assign o_done            = (state == DONE);
  assign o_busy            = (state != IDLE);
  assign o_beat_cnt        = cnt;

endmodule

// File: tb/tb_valtrain_pattern_gen.sv
// tb/tb_valtrain_pattern_gen.sv - scoreboard bench for valtrain_pattern_gen
module tb_valtrain_pattern_gen;

  localparam int CNT_W = 7;

  typedef struct {
    logic [31:0]      tvld;
    logic [CNT_W-1:0] cnt;
  } beat_t;

  logic             clk;
  logic             rst_n;
  logic             rst64_n;
  logic             pattern_en;
  logic             frame_en;
  logic [CNT_W-1:0] burst_len;
  logic             clear;
  logic             ready;

  logic [31:0]      tvld;
  logic             tvld_valid;
  logic             enable_detector;
  logic             done;
  logic             busy;
  logic [CNT_W-1:0] beat_cnt;

  logic [63:0]      tvld64;
  logic             tvld_valid64;
  logic             enable_detector64;
  logic             done64;
  logic             busy64;
  logic [CNT_W-1:0] beat_cnt64;

  int    checks;
  int    errors;
  beat_t sb[$];

  valtrain_pattern_gen #(.DATA_W(32), .CNT_W(CNT_W), .BASE_PAT(8'hF0)) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_pattern_en      (pattern_en),
    .i_frame_en        (frame_en),
    .i_burst_len       (burst_len),
    .i_clear           (clear),
    .i_ready           (ready),
    .o_tvld            (tvld),
    .o_tvld_valid      (tvld_valid),
    .o_enable_detector (enable_detector),
    .o_done            (done),
    .o_busy            (busy),
    .o_beat_cnt        (beat_cnt)
  );

  valtrain_pattern_gen #(.DATA_W(64), .CNT_W(CNT_W), .BASE_PAT(8'hF0)) dut64 (
    .i_clk             (clk),
    .i_rst_n           (rst64_n),
    .i_pattern_en      (pattern_en),
    .i_frame_en        (frame_en),
    .i_burst_len       (burst_len),
    .i_clear           (clear),
    .i_ready           (ready),
    .o_tvld            (tvld64),
    .o_tvld_valid      (tvld_valid64),
    .o_enable_detector (enable_detector64),
    .o_done            (done64),
    .o_busy            (busy64),
    .o_beat_cnt        (beat_cnt64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_burst(input int n, input int first);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.tvld = 32'hF0F0_F0F0;
      b.cnt  = CNT_W'(first + i);
      sb.push_back(b);
    end
  endtask

  // Inputs are already set for the coming edge; a transfer there consumes one expected beat.
  task automatic step();
    beat_t b;
    if (tvld_valid && ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 64'd1, 64'd0);
      end else begin
        b = sb.pop_front();
        check("sb_tvld", 64'(tvld), 64'(b.tvld));
        check("sb_cnt", 64'(beat_cnt), 64'(b.cnt));
      end
    end
    @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_tvld"}, 64'(tvld), 64'd0);
    check({tag, "_valid"}, 64'(tvld_valid), 64'd0);
    check({tag, "_det"}, 64'(enable_detector), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_cnt"}, 64'(beat_cnt), 64'd0);
  endtask

  initial begin
    logic       rdy_seq [5];
    logic [6:0] cnt_seq [5];
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    rst64_n = 1'b0;
    pattern_en = 1'b0;
    frame_en = 1'b0;
    burst_len = '0;
    clear = 1'b0;
    ready = 1'b0;
    rdy_seq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    cnt_seq = '{7'd0, 7'd1, 7'd1, 7'd2, 7'd2};

    @(negedge clk);
    @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    step();

    // Burst of 4 with ready always high
    pattern_en = 1'b1;
    burst_len = 7'd4;
    ready = 1'b1;
    push_burst(4, 0);
    check("b4_pre_valid", 64'(tvld_valid), 64'd0);
    step();
    for (int i = 0; i < 4; i++) begin
      check("b4_valid", 64'(tvld_valid), 64'd1);
      check("b4_det", 64'(enable_detector), 64'd1);
      check("b4_tvld", 64'(tvld), 64'hF0F0_F0F0);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      check("b4_done", 64'(done), 64'd1);
      check("b4_done_valid", 64'(tvld_valid), 64'd0);
      check("b4_done_det", 64'(enable_detector), 64'd0);
      check("b4_done_cnt", 64'(beat_cnt), 64'd4);
      step();
    end
    pattern_en = 1'b0;
    step();
    check_idle("b4_idle");

    // Burst of 3 with ready toggling
    pattern_en = 1'b1;
    burst_len = 7'd3;
    ready = 1'b1;
    push_burst(3, 0);
    step();
    for (int i = 0; i < 5; i++) begin
      ready = rdy_seq[i];
      check("b3_valid", 64'(tvld_valid), 64'd1);
      check("b3_cnt", 64'(beat_cnt), 64'(cnt_seq[i]));
      step();
    end
    check("b3_done", 64'(done), 64'd1);
    check("b3_done_cnt", 64'(beat_cnt), 64'd3);
    pattern_en = 1'b0;
    step();
    check_idle("b3_idle");

    // Length 0 means the full 128-beat burst
    pattern_en = 1'b1;
    burst_len = 7'd0;
    ready = 1'b1;
    push_burst(128, 0);
    step();
    for (int i = 0; i < 128; i++) begin
      check("b128_valid", 64'(tvld_valid), 64'd1);
      step();
    end
    check("b128_done", 64'(done), 64'd1);
    check("b128_done_cnt", 64'(beat_cnt), 64'd0);
    pattern_en = 1'b0;
    step();
    check_idle("b128_idle");

    // Framing for 10 cycles, serializer never ready
    frame_en = 1'b1;
    ready = 1'b0;
    step();
    for (int i = 0; i < 10; i++) begin
      check("frm_valid", 64'(tvld_valid), 64'd1);
      check("frm_tvld", 64'(tvld), 64'hF0F0_F0F0);
      check("frm_done", 64'(done), 64'd0);
      check("frm_det", 64'(enable_detector), 64'd0);
      check("frm_cnt", 64'(beat_cnt), 64'd0);
      if (i == 9) frame_en = 1'b0;
      step();
    end
    check_idle("frm_idle");

    // Both requests together: burst wins, then abort at beat 2
    pattern_en = 1'b1;
    frame_en = 1'b1;
    burst_len = 7'd5;
    ready = 1'b1;
    push_burst(2, 0);
    step();
    check("clr_det", 64'(enable_detector), 64'd1);
    check("clr_cnt0", 64'(beat_cnt), 64'd0);
    step();
    check("clr_cnt1", 64'(beat_cnt), 64'd1);
    step();
    check("clr_cnt2", 64'(beat_cnt), 64'd2);
    clear = 1'b1;
    ready = 1'b0;
    step();
    check_idle("clr_idle");
    clear = 1'b0;
    pattern_en = 1'b0;
    frame_en = 1'b0;
    step();
    check("clr_after_done", 64'(done), 64'd0);
    clear = 1'b1;
    step();
    check_idle("clr_noop");
    clear = 1'b0;
    step();

    // 64-bit build, reset dropped mid-burst
    rst64_n = 1'b1;
    pattern_en = 1'b1;
    burst_len = 7'd6;
    ready = 1'b1;
    push_burst(1, 0);
    step();
    check("w64_valid", 64'(tvld_valid64), 64'd1);
    check("w64_tvld", tvld64, 64'hF0F0_F0F0_F0F0_F0F0);
    step();
    check("w64_tvld2", tvld64, 64'hF0F0_F0F0_F0F0_F0F0);
    check("w64_cnt", 64'(beat_cnt64), 64'd1);
    #2;
    rst64_n = 1'b0;
    rst_n = 1'b0;
    #1;
    check("w64_rst_tvld", tvld64, 64'd0);
    check("w64_rst_valid", 64'(tvld_valid64), 64'd0);
    check("w64_rst_det", 64'(enable_detector64), 64'd0);
    check("w64_rst_done", 64'(done64), 64'd0);
    check("w64_rst_busy", 64'(busy64), 64'd0);
    check("w64_rst_cnt", 64'(beat_cnt64), 64'd0);
    check_idle("w32_rst");
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/valtrain_pattern_gen.md
Name: valtrain_pattern_gen

Overview:
- Parametrised valid-lane training pattern generator for the mainband TX path.
- Drives the 4-high/4-low valid pattern onto a DATA_W-bit serializer word in two modes:
  - bounded training burst, with a runtime-programmable beat count;
  - open-ended valid framing.
- Handshakes each beat with the serializer through a ready signal.
- Holds completion until the LTSM controller acknowledges it.
- Replaces the fixed 32-bit / 128-beat generator for variable serializer ratios and burst lengths.

Parameters:
- DATA_W, 32: output word width; must be a multiple of 8 and >= 8.
- CNT_W, 7: width of the beat counter and of i_burst_len.
- BASE_PAT, 8'hF0: 8-bit pattern unit, replicated DATA_W/8 times.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_pattern_en  in  1  request a training burst; level, held until o_done is seen.
- i_frame_en  in  1  valid-framing request; level.
- i_burst_len  in  CNT_W  beats per burst; 0 means 2^CNT_W. Sampled on the IDLE->PATTERN edge.
- i_clear  in  1  synchronous abort; returns to IDLE from any state.
- i_ready  in  1  serializer accepts the current word.
- o_tvld  out  DATA_W  pattern word; all zeros when not valid.
- o_tvld_valid  out  1  o_tvld carries pattern this cycle.
- o_enable_detector  out  1  high in PATTERN; enables the RX valid-pattern detector.
- o_done  out  1  burst complete; held until acknowledged.
- o_busy  out  1  state != IDLE.
- o_beat_cnt  out  CNT_W  beats accepted in the current burst.

Behaviour:
- States: IDLE, PATTERN, FRAMING, DONE. Registered state; all outputs decode from registered state and counters.
- Reset: state = IDLE; beat counter = 0; latched length = 0. Resulting outputs: o_tvld = 0, o_tvld_valid = 0, o_enable_detector = 0, o_done = 0, o_busy = 0, o_beat_cnt = 0.
- o_tvld = {DATA_W/8{BASE_PAT}} when o_tvld_valid = 1, else 0.
- o_tvld_valid = 1 in PATTERN or FRAMING.
- A beat transfers on a cycle where o_tvld_valid & i_ready = 1.

IDLE:
- i_pattern_en = 1 -> PATTERN next cycle. Latch i_burst_len; clear counter.
- Else i_frame_en = 1 -> FRAMING.
- i_pattern_en has priority when both are high.
- Latency: enable sampled at edge k, o_tvld_valid = 1 in cycle k+1.

PATTERN:
- Counter increments on each transferred beat. i_ready = 0 stalls: counter holds, word holds.
- On the transfer of the last beat (counter == len-1, with len 0 treated as 2^CNT_W, counter wrapping to 0) -> DONE next cycle.
- Exactly len beats are transferred.
- o_beat_cnt shows the accepted-beat count. In DONE it shows len mod 2^CNT_W.
- i_frame_en is ignored in PATTERN.
- Deasserting i_pattern_en mid-burst does not abort; only i_clear aborts.

DONE:
- o_done = 1, o_tvld_valid = 0, o_enable_detector = 0.
- Stays in DONE while i_pattern_en = 1.
- i_pattern_en = 0 -> IDLE next cycle; counter cleared.

FRAMING:
- o_tvld_valid = 1 every cycle. i_ready has no effect on state. Counter held at 0.
- i_frame_en = 0 -> IDLE next cycle.
- o_done is never asserted from FRAMING.

Abort and reset mid-operation:
- i_clear = 1 overrides all transitions: IDLE next cycle, counter cleared, o_done not asserted.
- i_clear in IDLE is a no-op.
- Reset mid-burst forces IDLE immediately (asynchronous).

Width rules:
- Counter is CNT_W bits and wraps modulo 2^CNT_W.
- len = 2^CNT_W is supported only via i_burst_len = 0.

Test Plan:
- Reset, then i_pattern_en = 1, i_burst_len = 4, i_ready = 1:
  - o_tvld = 32'hF0F0F0F0 with o_tvld_valid = 1 for exactly 4 cycles, starting 1 cycle after enable;
  - o_enable_detector high during those 4 cycles;
  - then o_done = 1 held until i_pattern_en drops, then IDLE with all outputs 0 the following cycle.
- Burst length 3, i_ready toggling 1,0,1,0,1: exactly 3 transfers, o_beat_cnt stepping 0->1->2; DONE entered after the 3rd accepted beat.
- i_burst_len = 0 with CNT_W = 7: 128 transfers, then o_done; o_beat_cnt = 0 in DONE.
- i_frame_en = 1 for 10 cycles with i_ready = 0: o_tvld_valid = 1 for 10 cycles; o_done never asserted; IDLE the cycle after i_frame_en falls.
- i_pattern_en and i_frame_en rise together: PATTERN entered. Then i_clear pulsed at beat 2: IDLE next cycle, o_done stays 0, o_tvld = 0.
- DATA_W = 64 build, reset asserted mid-burst: o_tvld = 64'hF0F0F0F0F0F0F0F0 during the burst; all outputs 0 immediately on reset assertion.
